// File: rtl/song_seq_pkg.sv
// Shared types and default constants for the song address sequencer.
// The sequencer walks one memory slot per song, either recording or playing back.
package song_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  localparam int DEF_ADDR_W     = 19;
  localparam int DEF_NUM_SLOTS  = 8;
  localparam int DEF_SLOT_DEPTH = 60000;
  localparam int DEF_SAMPLE_DIV = 2;
  localparam int DEF_DECIM      = 3;

  // Counter width that stays legal (>= 1 bit) for moduli of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Divides codec sample_en pulses into ticks and tracks the tick phase,
// flagging the ticks on which the sequencer takes an advance decision.
module sample_tick_gen
  import song_seq_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int DECIM      = DEF_DECIM
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic clear,
  input  logic hold,
  output logic advance_now
);

  localparam int DIV_W = cnt_w(SAMPLE_DIV);
  localparam int PH_W  = cnt_w(DECIM);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             tick;

  // Pulses arriving while held are dropped rather than deferred.
  always_comb begin
    tick  = 1'b0;
    div_d = div_q;
    ph_d  = ph_q;
    if (clear) begin
      div_d = '0;
      ph_d  = '0;
    end else if (sample_en && !hold) begin
      if (div_q == DIV_LAST) begin
        tick  = 1'b1;
        div_d = '0;
        ph_d  = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Decision uses the phase before this tick increments it.
  assign advance_now = tick && (ph_q == '0) && !clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      ph_q  <= '0;
    end else begin
      div_q <= div_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/song_addr_sequencer.sv
// Song memory address sequencer: records into or plays back from one of
// NUM_SLOTS fixed-size slots, keeping a per-slot recorded length.
module song_addr_sequencer
  import song_seq_pkg::*;
#(
  parameter  int ADDR_W     = DEF_ADDR_W,
  parameter  int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter  int SLOT_DEPTH = DEF_SLOT_DEPTH,
  parameter  int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter  int DECIM      = DEF_DECIM,
  localparam int SLOT_W     = cnt_w(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [SLOT_W-1:0] slot,
  input  logic              start,
  input  logic              pause,
  input  logic              record,
  input  logic              loop,
  output logic [ADDR_W-1:0] mem_address,
  output logic              addr_step,
  output logic              wrapped,
  output logic              song_done,
  output logic [ADDR_W-1:0] slot_len
);

  if (longint'(NUM_SLOTS) * longint'(SLOT_DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_size
    $error("song_addr_sequencer: NUM_SLOTS*SLOT_DEPTH exceeds the address space");
  end
  if (DECIM < 1 || SAMPLE_DIV < 1) begin : g_bad_div
    $error("song_addr_sequencer: DECIM and SAMPLE_DIV must be at least 1");
  end

  localparam logic [31:0]       NUM_SLOTS_U = 32'(NUM_SLOTS);
  localparam logic [ADDR_W-1:0] DEPTH_A     = ADDR_W'(SLOT_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_OFF    = ADDR_W'(SLOT_DEPTH - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              loop_q, loop_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W-1:0] len_q [NUM_SLOTS];

  logic              len_we;
  logic [SLOT_W-1:0] len_idx;
  logic [ADDR_W-1:0] len_wdata;
  logic              start_ok;
  logic              running;
  logic              advance_now;
  logic [ADDR_W-1:0] cur_len;

  assign start_ok = start && (32'(slot) < NUM_SLOTS_U);
  assign running  = (state_q == ST_RECORD) || (state_q == ST_PLAY);
  assign cur_len  = len_q[slot_q];

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .DECIM      (DECIM)
  ) u_tick (
    .clk         (clk),
    .reset       (reset),
    .sample_en   (sample_en),
    .clear       (start_ok),
    .hold        (pause || !running),
    .advance_now (advance_now)
  );

  // A valid start overrides any advance decision landing in the same cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    off_d     = off_q;
    slot_d    = slot_q;
    loop_d    = loop_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    len_we    = 1'b0;
    len_idx   = slot_q;
    len_wdata = '0;
    if (start_ok) begin
      slot_d  = slot;
      loop_d  = loop;
      addr_d  = ADDR_W'(slot) * DEPTH_A;
      off_d   = '0;
      state_d = record ? ST_RECORD : ST_PLAY;
      if (record) begin
        len_we  = 1'b1;
        len_idx = slot;
      end
    end else if (advance_now) begin
      case (state_q)
        ST_RECORD: begin
          if (off_q < LAST_OFF) begin
            addr_d    = addr_q + ADDR_W'(1);
            off_d     = off_q + ADDR_W'(1);
            step_d    = 1'b1;
            len_we    = 1'b1;
            len_wdata = off_q + ADDR_W'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_PLAY: begin
          if (off_q < cur_len) begin
            addr_d = addr_q + ADDR_W'(1);
            off_d  = off_q + ADDR_W'(1);
            step_d = 1'b1;
          end else if (loop_q && (cur_len != '0)) begin
            addr_d = addr_q - off_q;
            off_d  = '0;
            step_d = 1'b1;
            wrap_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      slot_q  <= '0;
      loop_q  <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      slot_q  <= slot_d;
      loop_q  <= loop_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      if (len_we) len_q[len_idx] <= len_wdata;
    end
  end

  assign mem_address = addr_q;
  assign addr_step   = step_q;
  assign wrapped     = wrap_q;
  assign song_done   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign slot_len    = cur_len;

endmodule

// File: tb/tb_song_addr_sequencer.sv
// Bench for song_addr_sequencer: table rows, corner-case sequences and random
// traffic, all checked every cycle against a pulse-counting reference model.
module tb_song_addr_sequencer;

  localparam int AW    = 5;
  localparam int NS    = 4;
  localparam int DEPTH = 8;
  localparam int SDIV  = 2;
  localparam int DEC   = 3;

  localparam int M_IDLE = 0, M_REC = 1, M_PLAY = 2, M_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, sample_en, start, pause, record, loop;
  logic [1:0]    slot;
  logic [AW-1:0] mem_address, slot_len;
  logic          addr_step, wrapped, song_done;

  song_addr_sequencer #(
    .ADDR_W(AW), .NUM_SLOTS(NS), .SLOT_DEPTH(DEPTH), .SAMPLE_DIV(SDIV), .DECIM(DEC)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .slot(slot), .start(start),
    .pause(pause), .record(record), .loop(loop), .mem_address(mem_address),
    .addr_step(addr_step), .wrapped(wrapped), .song_done(song_done), .slot_len(slot_len)
  );

  int n_vec = 0;
  int n_bad = 0;
  int row_steps, row_wraps;

  // Reference state: counted pulses since start, offset within slot, lengths.
  int m_mode, m_slot, m_off, m_cnt;
  bit m_loop, m_step, m_wrap;
  int m_len [NS];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit st, input int sl, input bit rec,
                            input bit lp, input bit pa, input bit se);
    m_step = 0;
    m_wrap = 0;
    if (r) begin
      m_mode = M_IDLE; m_slot = 0; m_off = 0; m_cnt = 0; m_loop = 0;
      for (int i = 0; i < NS; i++) m_len[i] = 0;
    end else if (st && sl < NS) begin
      m_slot = sl; m_loop = lp; m_off = 0; m_cnt = 0;
      m_mode = rec ? M_REC : M_PLAY;
      if (rec) m_len[sl] = 0;
    end else if ((m_mode == M_REC || m_mode == M_PLAY) && !pa && se) begin
      m_cnt++;
      if (m_cnt % SDIV == 0 && ((m_cnt / SDIV) - 1) % DEC == 0) begin
        if (m_mode == M_REC) begin
          if (m_off < DEPTH - 1) begin
            m_off++; m_len[m_slot] = m_off; m_step = 1;
          end else m_mode = M_DONE;
        end else if (m_off < m_len[m_slot]) begin
          m_off++; m_step = 1;
        end else if (m_loop && m_len[m_slot] > 0) begin
          m_off = 0; m_step = 1; m_wrap = 1;
        end else m_mode = M_DONE;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit st, input int sl, input bit rec,
                     input bit lp, input bit pa, input bit se);
    logic [1:0] s2;
    s2 = 2'(sl);
    reset = r; start = st; slot = s2; record = rec; loop = lp; pause = pa; sample_en = se;
    model_step(r, st, sl, rec, lp, pa, se);
    @(posedge clk);
    #1;
    row_steps += int'(addr_step);
    row_wraps += int'(wrapped);
    check("mem_address", int'(mem_address), m_slot * DEPTH + m_off);
    check("addr_step", int'(addr_step), int'(m_step));
    check("wrapped", int'(wrapped), int'(m_wrap));
    check("song_done", int'(song_done), (m_mode == M_IDLE || m_mode == M_DONE) ? 1 : 0);
    check("slot_len", int'(slot_len), m_len[m_slot]);
  endtask

  task automatic pulses(input int n, input bit pa);
    for (int k = 0; k < n; k++) begin
      cyc(0, 0, 0, 0, 0, pa, 1);
      cyc(0, 0, 0, 0, 0, pa, 0);
    end
  endtask

  typedef struct {
    bit rst; bit st; int sl; bit rec; bit lp; bit pa; int npulse;
    int e_addr; int e_done; int e_len; int e_steps; int e_wraps;
  } vec_t;

  vec_t tbl [7];

  initial begin
    bit r, st, rec, lp, pa, se;
    int sl;

    reset = 1'b0; sample_en = 1'b0; start = 1'b0; pause = 1'b0;
    record = 1'b0; loop = 1'b0; slot = 2'd0;
    row_steps = 0; row_wraps = 0;

    tbl[0] = '{1, 0, 0, 0, 0, 0,  0,  0, 1, 0,  0, 0};
    tbl[1] = '{0, 1, 2, 1, 0, 0, 60, 23, 1, 7,  7, 0};
    tbl[2] = '{0, 1, 2, 0, 0, 0, 60, 23, 1, 7,  7, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 0,  6,  8, 1, 0,  0, 0};
    tbl[4] = '{0, 1, 2, 0, 1, 0, 48, 16, 0, 7,  8, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 96, 16, 0, 7, 16, 2};
    tbl[6] = '{0, 1, 3, 1, 0, 0, 10, 26, 0, 2,  2, 0};

    for (int i = 0; i < 7; i++) begin
      row_steps = 0; row_wraps = 0;
      if (tbl[i].rst) cyc(1, 0, 0, 0, 0, 0, 0);
      if (tbl[i].st) cyc(0, 1, tbl[i].sl, tbl[i].rec, tbl[i].lp, 0, 0);
      pulses(tbl[i].npulse, tbl[i].pa);
      check($sformatf("row%0d addr", i), int'(mem_address), tbl[i].e_addr);
      check($sformatf("row%0d done", i), int'(song_done), tbl[i].e_done);
      check($sformatf("row%0d len", i), int'(slot_len), tbl[i].e_len);
      check($sformatf("row%0d steps", i), row_steps, tbl[i].e_steps);
      check($sformatf("row%0d wraps", i), row_wraps, tbl[i].e_wraps);
    end

    // Pause mid-record: frozen for 20 pulses, then resumes at the same phase.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    pulses(10, 0);
    check("pause pre addr", int'(mem_address), 2);
    row_steps = 0;
    pulses(20, 1);
    check("pause frozen addr", int'(mem_address), 2);
    check("pause steps", row_steps, 0);
    pulses(3, 0);
    check("resume addr before decision", int'(mem_address), 2);
    pulses(1, 0);
    check("resume addr after decision", int'(mem_address), 3);

    // Start on slot 3 in the same cycle as an advance decision of slot 0.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    pulses(7, 0);
    check("prio pre addr", int'(mem_address), 1);
    cyc(0, 1, 3, 0, 0, 0, 1);
    check("prio addr", int'(mem_address), 24);
    check("prio step", int'(addr_step), 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    check("prio len0 retained", int'(slot_len), 1);

    // Reset in the middle of looping playback.
    pulses(10, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst addr", int'(mem_address), 0);
    check("rst done", int'(song_done), 1);
    check("rst step", int'(addr_step), 0);
    check("rst wrap", int'(wrapped), 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("rst len cleared", int'(slot_len), 0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      r   = ($urandom_range(0, 799) == 0);
      st  = ($urandom_range(0, 119) == 0);
      sl  = int'($urandom_range(0, NS - 1));
      rec = 1'($urandom_range(0, 1));
      lp  = 1'($urandom_range(0, 1));
      pa  = ($urandom_range(0, 9) == 0);
      se  = 1'($urandom_range(0, 1));
      cyc(r, st, sl, rec, lp, pa, se);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
